// File: rtl/apb_rr_master_if.sv
// apb_rev_c_if: APB rev C bus signals shared between one master and the fabric.
// The master modport drives the request side; the slave modport answers it.
interface apb_rev_c_if;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, pprot, pselx, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, pselx, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin arbiter plus APB rev C master.
// NUM_REQ requesters each hand over one transfer with valid/ready. The winner's
// fields are registered onto the shared APB bus, the SETUP and ACCESS phases are
// run, and the result comes back as a one-cycle pulse on resp_valid[winner].
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that waits
// TIMEOUT_CYCLES cycles without pready (the response then carries resp_err=1).
module apb_rr_master #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]  req_strb,
  input  logic [NUM_REQ*3-1:0]  req_prot,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  apb_rev_c_if.master           apb
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Parameter sanity checks, evaluated at elaboration only.
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
      $error("apb_rr_master: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
      $error("apb_rr_master: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  state_t             state_reg;
  state_t             state_next;
  logic [IDX_W-1:0]   last_grant_reg;
  logic [IDX_W-1:0]   grant_reg;

  logic [31:0]        addr_arr  [NUM_REQ];
  logic [31:0]        wdata_arr [NUM_REQ];
  logic [3:0]         strb_arr  [NUM_REQ];
  logic [2:0]         prot_arr  [NUM_REQ];

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               accept;
  logic               complete;
  logic               timeout;
  logic               timeout_hit;

  logic [31:0]        paddr_reg;
  logic [2:0]         pprot_reg;
  logic               pselx_reg;
  logic               penable_reg;
  logic               pwrite_reg;
  logic [31:0]        pwdata_reg;
  logic [3:0]         pstrb_reg;

  logic [NUM_REQ-1:0] resp_valid_reg;
  logic [31:0]        resp_rdata_reg;
  logic               resp_err_reg;

  // Slice the flattened request vectors into per-requester views.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*32 +: 32];
      assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
      assign strb_arr[gi]  = req_strb[gi*4 +: 4];
      assign prot_arr[gi]  = req_prot[gi*3 +: 3];
    end
  endgenerate

  // Round-robin search: start one past the last winner, first valid requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Handshake only in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && presetn && pick_found) begin
      req_ready[pick_idx] = 1'b1;
    end
  end

  assign accept = (state_reg == IDLE) && pick_found;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_reg;

  // The terminal count is the TIMEOUT_CYCLES-th ACCESS cycle; pready there still wins.
  assign timeout_hit = (state_reg == ACCESS) && !apb.pready &&
                       (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles spent waiting; restart from zero every time ACCESS is entered.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == SETUP) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ACCESS && !apb.pready && !timeout_hit) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Phase sequencing and completion detection.
  always_comb begin
    state_next = state_reg;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (apb.pready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset lands in IDLE with requester 0 next in line.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      grant_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_grant_reg <= pick_idx;
        grant_reg      <= pick_idx;
      end
    end
  end

  // APB output registers: address/data fields load on accept and hold afterwards.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr_reg   <= '0;
      pprot_reg   <= '0;
      pselx_reg   <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      pwdata_reg  <= '0;
      pstrb_reg   <= '0;
    end else begin
      pselx_reg   <= (state_next == SETUP) || (state_next == ACCESS);
      penable_reg <= (state_next == ACCESS);
      if (accept) begin
        paddr_reg  <= addr_arr[pick_idx];
        pprot_reg  <= prot_arr[pick_idx];
        pwrite_reg <= req_write[pick_idx];
        // Reads never put requester data or strobes on the bus.
        pwdata_reg <= req_write[pick_idx] ? wdata_arr[pick_idx] : 32'd0;
        pstrb_reg  <= req_write[pick_idx] ? strb_arr[pick_idx]  : 4'd0;
      end
    end
  end

  // Response pulse to the granted requester the cycle after completion or abort.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      resp_valid_reg <= '0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= '0;
      if (complete) begin
        resp_valid_reg[grant_reg] <= 1'b1;
        resp_rdata_reg            <= pwrite_reg ? 32'd0 : apb.prdata;
        resp_err_reg              <= apb.pslverr;
      end else if (timeout) begin
        resp_valid_reg[grant_reg] <= 1'b1;
        resp_rdata_reg            <= 32'd0;
        resp_err_reg              <= 1'b1;
      end
    end
  end

  assign apb.paddr   = paddr_reg;
  assign apb.pprot   = pprot_reg;
  assign apb.pselx   = pselx_reg;
  assign apb.penable = penable_reg;
  assign apb.pwrite  = pwrite_reg;
  assign apb.pwdata  = pwdata_reg;
  assign apb.pstrb   = pstrb_reg;

  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule
